// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Latch-control bundle is ordered pc, ifid(en,flush), idex(en,flush), exmem, memwb(en,bubble).
package pipe_ctrl_pkg;

    localparam int REG_W = 3;
    localparam logic [1:0] DRAIN_DEPTH = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = 8'b1101_0110;
    localparam ctrl_t CTRL_STALL  = 8'b0000_0011;
    localparam ctrl_t CTRL_BRANCH = 8'b1111_1110;
    localparam ctrl_t CTRL_LU     = 8'b0001_1110;
    localparam ctrl_t CTRL_DRAIN  = 8'b0111_0110;
    localparam ctrl_t CTRL_OFF    = 8'b0000_0000;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between ID/EX load and IF/ID sources.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_rs_used,
    input  logic             ifid_rt_used,
    output logic             load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = ifid_rs_used && (ifid_rs == idex_rd);
    assign rt_hit   = ifid_rt_used && (ifid_rt == idex_rd);
    assign load_use = idex_memread && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/halt controller with optional perf counters.
// Define PIPE_CTRL_PERF_EN to build the stall_cnt/flush_cnt counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_rs_used,
    input  logic             ifid_rt_used,
    input  logic             ex_branch_taken,
    input  logic             id_halt,
    input  logic             mem_stall,
    input  logic             mem_done,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             memwb_bubble,
    output logic             halted,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt
);

    state_t     state;
    state_t     state_nx;
    logic [1:0] drain_cnt;
    logic [1:0] drain_cnt_nx;
    logic       drain_wait;
    logic       drain_wait_nx;
    logic       load_use;
    ctrl_t      ctrl;

    hazard_detect u_hazard (
        .idex_memread (idex_memread),
        .idex_rd      (idex_rd),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_rs_used (ifid_rs_used),
        .ifid_rt_used (ifid_rt_used),
        .load_use     (load_use)
    );

    // A memory access started in DRAIN is held until mem_done, like MEM_WAIT.
    logic drain_hold;
    logic drain_go;
    logic mem_block;
    logic run_live;
    logic ev_branch;
    logic ev_lu;
    logic ev_halt;

    assign drain_hold = drain_wait ? !mem_done : mem_stall;
    assign drain_go   = (state == ST_DRAIN) && !drain_hold;
    assign mem_block  = ((state == ST_RUN) && mem_stall)
                     || ((state == ST_MEM_WAIT) && !mem_done)
                     || ((state == ST_DRAIN) && drain_hold);
    assign run_live   = ((state == ST_RUN) && !mem_stall)
                     || ((state == ST_MEM_WAIT) && mem_done);
    assign ev_branch  = run_live && ex_branch_taken;
    assign ev_lu      = run_live && !ex_branch_taken && load_use;
    assign ev_halt    = run_live && !ex_branch_taken && !load_use && id_halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            drain_cnt  <= '0;
            drain_wait <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_nx;
            drain_cnt  <= drain_cnt_nx;
            drain_wait <= drain_wait_nx;
            halted     <= (state_nx == ST_HALTED);
        end
    end

    always_comb begin
        state_nx      = state;
        drain_cnt_nx  = drain_cnt;
        drain_wait_nx = drain_wait;
        case (state)
            ST_RUN, ST_MEM_WAIT: begin
                if (ev_halt) begin
                    state_nx      = ST_DRAIN;
                    drain_cnt_nx  = DRAIN_DEPTH;
                    drain_wait_nx = 1'b0;
                end else if (mem_block) begin
                    state_nx = ST_MEM_WAIT;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_wait && mem_done)
                    drain_wait_nx = 1'b0;
                else if (!drain_wait && mem_stall)
                    drain_wait_nx = 1'b1;
                if (drain_go) begin
                    drain_cnt_nx = drain_cnt - 2'd1;
                    if (drain_cnt == 2'd1)
                        state_nx = ST_HALTED;
                end
            end
            default: state_nx = ST_HALTED;
        endcase
    end

    always_comb begin
        ctrl = CTRL_RUN;
        if (rst_n) begin
            unique case (1'b1)
                state == ST_HALTED: ctrl = CTRL_OFF;
                mem_block:          ctrl = CTRL_STALL;
                ev_branch:          ctrl = CTRL_BRANCH;
                ev_lu:              ctrl = CTRL_LU;
                drain_go:           ctrl = CTRL_DRAIN;
                default:            ctrl = CTRL_RUN;
            endcase
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign ifid_en      = ctrl.ifid_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_en      = ctrl.idex_en;
    assign idex_flush   = ctrl.idex_flush;
    assign exmem_en     = ctrl.exmem_en;
    assign memwb_en     = ctrl.memwb_en;
    assign memwb_bubble = ctrl.memwb_bubble;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;
    logic        stall_ev;

    assign stall_ev = ((state == ST_RUN) || (state == ST_MEM_WAIT))
                   && !ctrl.pc_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_ev && (stall_q != 16'hFFFF))
                stall_q <= stall_q + 16'd1;
            if (ev_branch && (flush_q != 16'hFFFF))
                flush_q <= flush_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
